// File: rtl/vga_timing_gen.sv
// 800x525 raster timing source (CLK/2 pixel clock); outputs registered on the pixel tick.
// Latency: DrawX/DrawY/hs/vs/blank describe the same pixel with zero skew; free-running, no backpressure.
module vga_timing_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       CLK,
  input  logic       Reset_n,
  output logic       VGA_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       line_start
);

  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VISW = 10'(H_VIS);
  localparam logic [9:0] V_VISW = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;

  // The tick is the edge where VGA_clk falls, so it is simply the current VGA_clk level.
  assign tick = VGA_clk;

  always_comb begin
    h_wrap = (DrawX == H_LAST);
    v_wrap = (DrawY == V_LAST);
    hc_nxt = h_wrap ? 10'd0 : DrawX + 10'd1;
    vc_nxt = DrawY;
    if (h_wrap) begin
      vc_nxt = v_wrap ? 10'd0 : DrawY + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_clk <= 1'b0;
    end else begin
      VGA_clk <= ~VGA_clk;
    end
  end

  // Syncs and blank are derived from the next counter values so they line up with DrawX/DrawY.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      DrawX <= 10'd0;
      DrawY <= 10'd0;
      hs    <= 1'b1;
      vs    <= 1'b1;
      blank <= 1'b1;
    end else if (tick) begin
      DrawX <= hc_nxt;
      DrawY <= vc_nxt;
      hs    <= !((hc_nxt >= HS_BEG) && (hc_nxt < HS_END));
      vs    <= !((vc_nxt >= VS_BEG) && (vc_nxt < VS_END));
      blank <= (hc_nxt < H_VISW) && (vc_nxt < V_VISW);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for reset/line checks, a shrunken-geometry
// instance for frame, corner and mid-line reset checks; per-tick expectations go through queues.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
  } smp_t;

  typedef struct packed {
    int hvis; int hfp; int hsync; int hbp;
    int vvis; int vfp; int vsync; int vbp;
  } geo_t;

  localparam geo_t GA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geo_t GB = '{8, 2, 3, 3, 6, 1, 2, 2};
  localparam smp_t RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1, ls: 1'b0, fs: 1'b0};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       vclk_a, hs_a, vs_a, bl_a, fs_a, ls_a;
  logic       vclk_b, hs_b, vs_b, bl_b, fs_b, ls_b;
  logic [9:0] x_a, y_a, x_b, y_b;

  always #10 clk = ~clk;

  vga_timing_gen dut_a (
    .CLK(clk), .Reset_n(rst_a), .VGA_clk(vclk_a), .hs(hs_a), .vs(vs_a), .blank(bl_a),
    .DrawX(x_a), .DrawY(y_a), .frame_start(fs_a), .line_start(ls_a)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .CLK(clk), .Reset_n(rst_b), .VGA_clk(vclk_b), .hs(hs_b), .vs(vs_b), .blank(bl_b),
    .DrawX(x_b), .DrawY(y_b), .frame_start(fs_b), .line_start(ls_b)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n;
  smp_t qa[$];
  smp_t qb[$];
  smp_t last_a, last_b, hold;
  bit   pv_a, pv_b;
  bit   run_a = 0, run_b = 0;
  bit   prev_bl_a = 1'b1;
  int   hs_low_a = 0, hs_first_a = -1, blank_fall_a = -1, ls_cyc_a = 0;
  int   tick_b = 0, vs_low_b = 0, vs_first_x = -1, vs_first_y = -1, blank_cnt_b = 0;
  int   fs_cnt_b = 0, fs_t0 = 0, fs_t1 = 0;

  // Expected raster state k pixel ticks after reset release, from absolute position arithmetic.
  function automatic smp_t model(geo_t g, int k);
    int   ht, vt, x, y;
    smp_t s;
    ht = g.hvis + g.hfp + g.hsync + g.hbp;
    vt = g.vvis + g.vfp + g.vsync + g.vbp;
    x = k % ht;
    y = (k / ht) % vt;
    s.x = 10'(x);
    s.y = 10'(y);
    s.hs = !((x >= g.hvis + g.hfp) && (x < g.hvis + g.hfp + g.hsync));
    s.vs = !((y >= g.vvis + g.vfp) && (y < g.vvis + g.vfp + g.vsync));
    s.blank = (x < g.hvis) && (y < g.vvis);
    s.ls = (k > 0) && (x == 0);
    s.fs = s.ls && (y == 0);
    return s;
  endfunction

  function automatic smp_t sa();
    return smp_t'({x_a, y_a, hs_a, vs_a, bl_a, ls_a, fs_a});
  endfunction

  function automatic smp_t sb();
    return smp_t'({x_b, y_b, hs_b, vs_b, bl_b, ls_b, fs_b});
  endfunction

  task automatic check(input string name, input smp_t got, input smp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b",
               name, $time, got.x, got.y, got.hs, got.vs, got.blank, got.ls, got.fs,
               exp.x, exp.y, exp.hs, exp.vs, exp.blank, exp.ls, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor A: a tick is seen as VGA_clk 1 -> 0 between successive negedge samples.
  initial forever begin
    @(negedge clk);
    if (!rst_a) begin
      pv_a = 1'b0;
    end else begin
      if (qa.size() > 0) begin
        if (pv_a && !vclk_a) begin
          last_a = qa.pop_front();
          check("line_tick", sa(), last_a);
          if (!hs_a) begin
            hs_low_a++;
            if (hs_first_a < 0) hs_first_a = int'(x_a);
          end
          if (prev_bl_a && !bl_a && blank_fall_a < 0) blank_fall_a = int'(x_a);
          prev_bl_a = bl_a;
        end else begin
          hold = last_a;
          hold.ls = 1'b0;
          hold.fs = 1'b0;
          check("line_hold", sa(), hold);
        end
      end
      if (run_a && ls_a) ls_cyc_a++;
      pv_a = vclk_a;
    end
  end

  // Monitor B: same scheme, plus frame-level measurements over the first two frames.
  initial forever begin
    @(negedge clk);
    if (!rst_b) begin
      pv_b = 1'b0;
    end else begin
      if (qb.size() > 0) begin
        if (pv_b && !vclk_b) begin
          last_b = qb.pop_front();
          tick_b++;
          check("frame_tick", sb(), last_b);
          if (run_b && tick_b <= 352) begin
            if (!vs_b) begin
              vs_low_b++;
              if (vs_first_x < 0) begin
                vs_first_x = int'(x_b);
                vs_first_y = int'(y_b);
              end
            end
            if (bl_b) blank_cnt_b++;
          end
        end else begin
          hold = last_b;
          hold.ls = 1'b0;
          hold.fs = 1'b0;
          check("frame_hold", sb(), hold);
        end
      end
      if (run_b && fs_b) begin
        fs_cnt_b++;
        if (fs_cnt_b == 1) fs_t0 = cyc;
        if (fs_cnt_b == 2) fs_t1 = cyc;
      end
      pv_b = vclk_b;
    end
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("reset_a", sa(), RST);
    check_int("reset_vclk_a", int'(vclk_a), 0);
    check("reset_b", sb(), RST);
    check_int("reset_vclk_b", int'(vclk_b), 0);

    // One full line on the full-size raster, ending on the wrap to DrawX=0.
    for (int k = 1; k <= 800; k++) qa.push_back(model(GA, k));
    last_a = RST;
    run_a = 1'b1;
    rst_a = 1'b1;
    n = 0;
    while (qa.size() > 0 && n < 2000) begin
      @(posedge clk);
      #3;
      n++;
    end
    run_a = 1'b0;
    check_int("drain_line", qa.size(), 0);
    check_int("hs_low_ticks", hs_low_a, 96);
    check_int("hs_first_x", hs_first_a, 656);
    check_int("blank_fall_x", blank_fall_a, 640);
    check_int("line_start_cycles", ls_cyc_a, 1);

    // Two frames plus a partial third on the small raster, stopping at (5,4).
    for (int k = 1; k <= 421; k++) qb.push_back(model(GB, k));
    last_b = RST;
    run_b = 1'b1;
    rst_b = 1'b1;
    n = 0;
    while (qb.size() > 0 && n < 1200) begin
      @(posedge clk);
      #3;
      n++;
    end
    run_b = 1'b0;
    check_int("drain_frames", qb.size(), 0);
    check_int("frame_start_count", fs_cnt_b, 2);
    check_int("frame_period_clk", fs_t1 - fs_t0, 352);
    check_int("vs_low_ticks", vs_low_b, 64);
    check_int("vs_first_x", vs_first_x, 0);
    check_int("vs_first_y", vs_first_y, 7);
    check_int("blank_count", blank_cnt_b, 96);

    // Asynchronous reset mid-line, between CLK edges.
    check_int("pre_reset_x", int'(x_b), 5);
    check_int("pre_reset_y", int'(y_b), 4);
    rst_b = 1'b0;
    #2;
    check("async_reset_b", sb(), RST);
    check_int("async_reset_vclk_b", int'(vclk_b), 0);
    repeat (3) @(posedge clk);
    #3;
    tick_b = 0;
    for (int k = 1; k <= 40; k++) qb.push_back(model(GB, k));
    last_b = RST;
    rst_b = 1'b1;
    n = 0;
    while (qb.size() > 0 && n < 200) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_int("drain_restart", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
